// File: rtl/host_cmd_dec_if.sv
// rtl/host_cmd_dec_if.sv - host write bus and register-strobe bundle for host_cmd_dec
interface host_cmd_dec_if;
  logic       hst_cs_x;
  logic       hst_wr_x;
  logic       hst_a0;
  logic [7:0] hst_d;
  logic       reg_0x00_ce;
  logic       reg_0x01_ce;
  logic       reg_0x02_ce;
  logic       reg_0x03_ce;
  logic       reg_0x04_ce;
  logic       reg_0x05_ce;
  logic       reg_0x06_ce;
  logic       reg_0x07_ce;
  logic       reg_wrreq;
  logic [7:0] reg_wdata;
  logic [7:0] cmd_code;
  logic       cmd_stb;
  logic       prm_drop;

  modport master (
    output hst_cs_x, hst_wr_x, hst_a0, hst_d,
    input  reg_0x00_ce, reg_0x01_ce, reg_0x02_ce, reg_0x03_ce,
    input  reg_0x04_ce, reg_0x05_ce, reg_0x06_ce, reg_0x07_ce,
    input  reg_wrreq, reg_wdata, cmd_code, cmd_stb, prm_drop
  );

  modport slave (
    input  hst_cs_x, hst_wr_x, hst_a0, hst_d,
    output reg_0x00_ce, reg_0x01_ce, reg_0x02_ce, reg_0x03_ce,
    output reg_0x04_ce, reg_0x05_ce, reg_0x06_ce, reg_0x07_ce,
    output reg_wrreq, reg_wdata, cmd_code, cmd_stb, prm_drop
  );
endinterface

// File: rtl/host_cmd_dec.sv
// rtl/host_cmd_dec.sv - 8080 host write synchronizer and SYSTEM SET command/parameter decoder
module host_cmd_dec (
  input  logic           clk,
  input  logic           rst_x,
  host_cmd_dec_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYS  = 2'd1,
    ST_IGN  = 2'd2
  } state_t;

  logic       act;
  logic       s1, s2, s3;
  logic       wend;
  logic       wend_q;
  logic [7:0] cap_d;
  logic       cap_a0;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] ce_q, ce_d;
  logic       wrreq_q, wrreq_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] code_q, code_d;
  logic       stb_q, stb_d;
  logic       drop_q, drop_d;

  assign act  = ~bus.hst_cs_x & ~bus.hst_wr_x;
  assign wend = s3 & ~s2;

  // cap_* freezes once s2 falls, so it is stable while wend_q is consumed
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      wend_q <= 1'b0;
      cap_d  <= 8'h00;
      cap_a0 <= 1'b0;
    end else begin
      s1     <= act;
      s2     <= s1;
      s3     <= s2;
      wend_q <= wend;
      if (s2) begin
        cap_d  <= bus.hst_d;
        cap_a0 <= bus.hst_a0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      ce_q    <= 8'h00;
      wrreq_q <= 1'b0;
      wdata_q <= 8'h00;
      code_q  <= 8'h00;
      stb_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ce_q    <= ce_d;
      wrreq_q <= wrreq_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
      stb_q   <= stb_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ce_d    = 8'h00;
    wrreq_d = 1'b0;
    wdata_d = wdata_q;
    code_d  = code_q;
    stb_d   = 1'b0;
    drop_d  = 1'b0;
    if (wend_q) begin
      if (cap_a0) begin
        code_d = cap_d;
        stb_d  = 1'b1;
        if (cap_d == 8'h40) begin
          state_d = ST_SYS;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_IGN;
        end
      end else begin
        case (state_q)
          ST_SYS: begin
            wrreq_d = 1'b1;
            ce_d    = 8'h01 << idx_q;
            wdata_d = cap_d;
            idx_d   = idx_q + 3'd1;
            // P8 closes the sequence; further parameters are dropped, not wrapped
            if (idx_q == 3'd7) begin
              state_d = ST_IGN;
            end
          end
          default: begin
            drop_d = 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.reg_0x00_ce = ce_q[0];
  assign bus.reg_0x01_ce = ce_q[1];
  assign bus.reg_0x02_ce = ce_q[2];
  assign bus.reg_0x03_ce = ce_q[3];
  assign bus.reg_0x04_ce = ce_q[4];
  assign bus.reg_0x05_ce = ce_q[5];
  assign bus.reg_0x06_ce = ce_q[6];
  assign bus.reg_0x07_ce = ce_q[7];
  assign bus.reg_wrreq   = wrreq_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.cmd_code    = code_q;
  assign bus.cmd_stb     = stb_q;
  assign bus.prm_drop    = drop_q;

endmodule

// File: tb/tb_host_cmd_dec.sv
// tb/tb_host_cmd_dec.sv - scoreboard bench for host_cmd_dec with randomized host writes
module tb_host_cmd_dec;

  localparam int K_REG  = 0;
  localparam int K_CMD  = 1;
  localparam int K_DROP = 2;

  typedef struct {
    int         kind;
    int         idx;
    logic [7:0] d;
  } exp_t;

  logic clk;
  logic rst_x;
  host_cmd_dec_if bus ();

  host_cmd_dec dut (
    .clk   (clk),
    .rst_x (rst_x),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       q[$];
  int         n_vec   = 0;
  int         n_err   = 0;
  int         n_pulse = 0;
  int         sys_cnt = 8;
  logic [7:0] regs_exp [8];
  logic [7:0] regs_act [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ce_vec();
    return {bus.reg_0x07_ce, bus.reg_0x06_ce, bus.reg_0x05_ce, bus.reg_0x04_ce,
            bus.reg_0x03_ce, bus.reg_0x02_ce, bus.reg_0x01_ce, bus.reg_0x00_ce};
  endfunction

  function automatic logic any_pulse();
    return bus.reg_wrreq | bus.cmd_stb | bus.prm_drop | (|ce_vec());
  endfunction

  // Reference: a SYSTEM SET opens an 8-slot window; everything else is a drop
  task automatic model_byte(input logic a0, input logic [7:0] d);
    exp_t e;
    e.d   = d;
    e.idx = 0;
    if (a0) begin
      e.kind  = K_CMD;
      sys_cnt = (d == 8'h40) ? 0 : 8;
    end else if (sys_cnt < 8) begin
      e.kind = K_REG;
      e.idx  = sys_cnt;
      regs_exp[sys_cnt] = d;
      sys_cnt++;
    end else begin
      e.kind = K_DROP;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_x && any_pulse()) begin
      automatic exp_t e;
      n_pulse++;
      chk("pulse_exclusive", 32'(bus.reg_wrreq) + 32'(bus.cmd_stb) + 32'(bus.prm_drop), 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {ce_vec(), 5'd0, bus.reg_wrreq, bus.cmd_stb, bus.prm_drop}, 32'd0);
      end else begin
        e = q.pop_front();
        case (e.kind)
          K_REG: begin
            chk("reg_wrreq", bus.reg_wrreq, 1'b1);
            chk("reg_ce", ce_vec(), 8'h01 << e.idx);
            chk("reg_wdata", bus.reg_wdata, e.d);
            if (bus.reg_wrreq) begin
              for (int i = 0; i < 8; i++) if (ce_vec()[i]) regs_act[i] = bus.reg_wdata;
            end
          end
          K_CMD: begin
            chk("cmd_stb", {ce_vec(), bus.cmd_stb}, 9'h001);
            chk("cmd_code", bus.cmd_code, e.d);
          end
          default: begin
            chk("prm_drop", {ce_vec(), bus.prm_drop}, 9'h001);
          end
        endcase
      end
    end
  end

  task automatic host_write(input logic a0, input logic [7:0] d);
    int lat;
    @(posedge clk);
    #1;
    bus.hst_a0   = a0;
    bus.hst_d    = d;
    bus.hst_cs_x = 1'b0;
    bus.hst_wr_x = 1'b0;
    model_byte(a0, d);
    repeat ($urandom_range(3, 10)) @(posedge clk);
    #($urandom_range(2, 9));
    bus.hst_cs_x = 1'b1;
    bus.hst_wr_x = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (any_pulse()) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat < 4 || lat > 5) begin
      n_err++;
      $display("FAIL latency: got %0d edges expected 4..5 (a0=%0b d=0x%0h)", lat, a0, d);
    end
    repeat ($urandom_range(3, 5)) @(posedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_x   = 1'b0;
    sys_cnt = 8;
    repeat (2) @(posedge clk);
    #3;
    rst_x = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pcnt;
    logic [7:0] sysset [8];
    sysset = '{8'h30, 8'h87, 8'h07, 8'h27, 8'h2F, 8'hEF, 8'h28, 8'h00};
    for (int i = 0; i < 8; i++) begin
      regs_exp[i] = 8'h00;
      regs_act[i] = 8'h00;
    end
    rst_x        = 1'b0;
    bus.hst_cs_x = 1'b1;
    bus.hst_wr_x = 1'b1;
    bus.hst_a0   = 1'b0;
    bus.hst_d    = 8'h00;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.hst_cs_x = 1'($urandom);
      bus.hst_wr_x = 1'($urandom);
      bus.hst_a0   = 1'($urandom);
      bus.hst_d    = 8'($urandom);
      #1;
      chk("reset_outputs", {ce_vec(), bus.reg_wrreq, bus.cmd_stb, bus.prm_drop, bus.reg_wdata, bus.cmd_code}, 32'd0);
    end
    bus.hst_cs_x = 1'b1;
    bus.hst_wr_x = 1'b1;
    @(negedge clk);
    #3;
    rst_x = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_quiet", n_pulse, 0);
    chk("post_reset_outputs", {ce_vec(), bus.reg_wrreq, bus.cmd_stb, bus.prm_drop, bus.reg_wdata, bus.cmd_code}, 32'd0);

    // strobe already low when reset releases
    @(negedge clk);
    rst_x        = 1'b0;
    sys_cnt      = 8;
    bus.hst_cs_x = 1'b0;
    bus.hst_wr_x = 1'b0;
    bus.hst_a0   = 1'b1;
    bus.hst_d    = 8'h12;
    model_byte(1'b1, 8'h12);
    @(negedge clk);
    #3;
    rst_x = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    bus.hst_cs_x = 1'b1;
    bus.hst_wr_x = 1'b1;
    repeat (8) @(posedge clk);
    chk("strobe_at_release", n_pulse, 1);

    host_write(1'b1, 8'h40);
    for (int i = 0; i < 8; i++) host_write(1'b0, sysset[i]);
    host_write(1'b0, 8'h55);

    host_write(1'b1, 8'h59);
    host_write(1'b0, 8'h01);
    host_write(1'b0, 8'h02);
    #1;
    chk("cmd_code_hold", bus.cmd_code, 8'h59);

    host_write(1'b1, 8'h40);
    host_write(1'b0, 8'h11);
    host_write(1'b0, 8'h22);
    host_write(1'b1, 8'h40);
    host_write(1'b0, 8'h33);

    host_write(1'b1, 8'h40);
    host_write(1'b0, 8'h11);
    host_write(1'b0, 8'h22);
    reset_pulse();
    host_write(1'b0, 8'h44);

    for (int i = 0; i < 40; i++) begin
      logic a0;
      logic [7:0] d;
      a0 = ($urandom_range(0, 3) == 0);
      d  = (a0 && $urandom_range(0, 1) == 0) ? 8'h40 : 8'($urandom);
      host_write(a0, d);
    end

    pcnt = n_pulse;
    bus.hst_cs_x = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.hst_a0   = 1'($urandom);
      bus.hst_d    = 8'($urandom);
      bus.hst_wr_x = 1'b0;
      repeat ($urandom_range(3, 6)) @(posedge clk);
      bus.hst_wr_x = 1'b1;
      repeat (3) @(posedge clk);
    end
    repeat (8) @(posedge clk);
    chk("cs_high_no_output", n_pulse, pcnt);

    repeat (10) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("reg_0x0%0d", i), regs_act[i], regs_exp[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/host_cmd_dec.md
# host_cmd_dec

Host bus front end for the S1D13700-compatible LCD controller core. Synchronizes the asynchronous 8080-style host write strobe into the `clk` domain and classifies each byte as command (A0=1) or parameter (A0=0). Tracks the SYSTEM SET (0x40) parameter sequence and produces the one-cycle `reg_0x00_ce`..`reg_0x07_ce`, `reg_wrreq` and `reg_wdata` strobes consumed by the host register file. Other command codes are published on `cmd_code`/`cmd_stb`; their parameters are discarded here.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `rst_x` in 1: reset, asynchronous, active-low.
- `hst_cs_x` in 1: host chip select, active-low, asynchronous.
- `hst_wr_x` in 1: host write strobe, active-low, asynchronous.
- `hst_a0` in 1: 1 = command byte, 0 = parameter byte.
- `hst_d` in 8: host write data.
- `reg_0x00_ce`..`reg_0x07_ce` out 1 each: one-hot register select, valid only with `reg_wrreq`.
- `reg_wrreq` out 1: one-cycle register write request.
- `reg_wdata` out 8: register write data, valid with `reg_wrreq`.
- `cmd_code` out 8: last accepted command byte.
- `cmd_stb` out 1: one-cycle pulse on every accepted command byte.
- `prm_drop` out 1: one-cycle pulse when a parameter byte is discarded.

## Operation
- Strobe `act = ~hst_cs_x & ~hst_wr_x`, passed through three flops `s1 -> s2 -> s3`, all reset to 0. Write end `wend = s3 & ~s2`.
- Each cycle with `s2 = 1`, capture `hst_d` into `cap_d` and `hst_a0` into `cap_a0`. Each `wend` processes one byte from `cap_d`/`cap_a0`.
- Command byte (`cap_a0 = 1`): `cmd_code <= cap_d`, `cmd_stb` pulses. If `cap_d == 8'h40`, state becomes SYS with `idx = 0`; otherwise state becomes IGN.
- FSM states: IDLE (after reset), SYS (collecting SYSTEM SET P1..P8), IGN (parameters discarded).
- Parameter byte in SYS: `reg_wrreq = 1`, `reg_0x0{idx}_ce = 1`, `reg_wdata = cap_d`, then `idx <= idx + 1` (3-bit). When `idx == 7`, the write to reg 0x07 is performed and state goes to IGN. There is no wrap.
- Parameter byte in IDLE or IGN: no register strobe, `prm_drop` pulses.
- A new command byte in any state, including mid-SYS, restarts the classification above. A SYSTEM SET interrupted after P5 leaves regs 0x05..0x07 untouched.
- `hst_rd_x` is not an input. Read cycles never create `act`.
- Reset values: all `ce`, `reg_wrreq`, `cmd_stb`, `prm_drop` = 0; `reg_wdata` = 0x00; `cmd_code` = 0x00; state IDLE; `idx` = 0; `cap_d` = 0x00; `cap_a0` = 0.
- Asynchronous reset mid-sequence returns to IDLE immediately. Any partial SYSTEM SET is abandoned.
- A strobe already active at reset release is processed normally at its end, using data captured after release.

## Timing
- All outputs are registered. Pulse outputs are high for exactly one `clk` cycle.
- `wend` is seen 3–4 `clk` rising edges after strobe release, depending on synchronizer phase. Outputs assert on the edge after `wend`, giving 4–5 edges total from WR#/CS# rise to output assertion.
- Host requirements:
  - Strobe low width ≥ 3 `clk` periods.
  - Strobe high time between writes ≥ 3 `clk` periods.
  - `hst_d`/`hst_a0` stable from ≥ 1 `clk` after strobe fall until strobe rise.
- Violating strobe width may drop the write. This is not detected.
- Maximum rate: one byte processed per `wend`. At most one of `reg_wrreq`, `cmd_stb`, `prm_drop` is high in any cycle.
- `cmd_code` updates in the same cycle that `cmd_stb` asserts.

## Test plan
- Reset check: hold `rst_x` low with random bus activity, release it → all outputs are 0/0x00 and no pulse occurs until a complete strobe is seen.
- Full SYSTEM SET: write cmd 0x40 then params 0x30,0x87,0x07,0x27,0x2F,0xEF,0x28,0x00 → 8 `reg_wrreq` pulses with ce 0x00..0x07 in order. `reg_wdata` matches each byte. The P5 write (ce 0x04, 0x2F) reaches `reg_tcr`. `cmd_stb` pulses once with `cmd_code` = 0x40.
- Overrun: the full SYSTEM SET followed by a 9th param 0x55 → no `reg_wrreq`, `prm_drop` pulses once, and the register contents are unchanged.
- Non-SYSTEM command: cmd 0x59 then params 0x01,0x02 → `cmd_code` = 0x59, `cmd_stb` pulses once, `prm_drop` pulses twice, no `reg_wrreq`.
- Interrupted sequence: cmd 0x40, params 0x11,0x22, then cmd 0x40, param 0x33 → ce 0x00 (0x11), ce 0x01 (0x22), then ce 0x00 (0x33). Also check: assert `rst_x` after the second param, then send param 0x44 → `prm_drop`, no `reg_wrreq`.
- Strobe timing sweep: strobe low widths of 3–10 clk, with release at random phase relative to `clk` → every write is processed exactly once. Output asserts 4–5 edges after release. Toggling `hst_wr_x` while `hst_cs_x` is high produces no output.
